shift_exchange_ctrl: RTL and testbench

Handshaked shift-exchange controller. It accepts a parallel word and shifts it out serially, one bit per programmable bit period, while shifting an equal number of serial bits in. When the exchange completes it presents the received word. It sits directly downstream of the parallel-word producer and upstream of any serial link (SPI-style exchange, loopback test). It owns its own shift register with universal-register semantics (hold, shift right, shift left, parallel load).

---
 rtl/shift_pkg.sv | 18 +
 rtl/bit_period_counter.sv | 44 ++++
 rtl/shift_exchange_ctrl.sv | 112 +++++++++++
 tb/tb_shift_exchange_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// +--------------------------------------------------------------------+
// | shift_pkg : state and direction encodings for shift_exchange_ctrl  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package shift_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/bit_period_counter.sv
// +--------------------------------------------------------------------+
// | bit_period_counter : counts 0..DIV-1, tick at DIV-1                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module bit_period_counter #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = enable_i && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/shift_exchange_ctrl.sv
// +--------------------------------------------------------------------+
// | shift_exchange_ctrl : handshaked serial shift-out / shift-in       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module shift_exchange_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] In,
  input  logic             Dir,
  input  logic             InValid,
  output logic             InReady,
  input  logic             SerialIn,
  output logic             SerialOut,
  output logic [WIDTH-1:0] Q,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] RxWord
);

  localparam int            BW      = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LASTBIT = BW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic             dir_q, dir_d;

  logic             accept;
  logic             tick;
  logic             in_shift;
  logic [WIDTH-1:0] shifted;

  assign accept   = (state_q == ST_IDLE) && InValid;
  assign in_shift = (state_q == ST_SHIFT);
  assign shifted  = (dir_q == DIR_LEFT) ? {q_q[WIDTH-2:0], SerialIn}
                                        : {SerialIn, q_q[WIDTH-1:1]};

  bit_period_counter #(
    .DIV (DIV)
  ) u_bit_period_counter (
    .clk_i    (Clk),
    .rst_i    (Rst),
    .clear_i  (accept),
    .enable_i (in_shift),
    .tick_o   (tick)
  );

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    rx_d     = rx_q;
    bitcnt_d = bitcnt_q;
    dir_d    = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          q_d      = In;
          dir_d    = Dir;
          bitcnt_d = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          q_d      = shifted;
          bitcnt_d = bitcnt_q + 1'b1;
          // The last shift edge captures the completed word directly.
          if (bitcnt_q == LASTBIT) begin
            rx_d    = shifted;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= ST_IDLE;
      q_q      <= '0;
      rx_q     <= '0;
      bitcnt_q <= '0;
      dir_q    <= DIR_RIGHT;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      rx_q     <= rx_d;
      bitcnt_q <= bitcnt_d;
      dir_q    <= dir_d;
    end
  end

  assign InReady   = (state_q == ST_IDLE);
  assign Busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign Done      = (state_q == ST_DONE);
  assign SerialOut = in_shift && ((dir_q == DIR_LEFT) ? q_q[WIDTH-1] : q_q[0]);
  assign Q         = q_q;
  assign RxWord    = rx_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_exchange_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_shift_exchange_ctrl : directed bench, WIDTH=4 with DIV=2 and 1  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_shift_exchange_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DIV=2 instance
  logic [3:0] a_in = '0;
  logic       a_dir = 1'b0, a_valid = 1'b0, a_sin = 1'b0, loop_a = 1'b0;
  logic       a_rdy, a_so, a_busy, a_done;
  logic [3:0] a_q, a_rx;
  wire        a_sin_w = loop_a ? a_so : a_sin;

  shift_exchange_ctrl #(.WIDTH(4), .DIV(2)) dut_a (
    .Clk(clk), .Rst(rst), .In(a_in), .Dir(a_dir), .InValid(a_valid),
    .InReady(a_rdy), .SerialIn(a_sin_w), .SerialOut(a_so), .Q(a_q),
    .Busy(a_busy), .Done(a_done), .RxWord(a_rx)
  );

  // DIV=1 instance, always in loopback
  logic [3:0] b_in = '0;
  logic       b_dir = 1'b0, b_valid = 1'b0;
  logic       b_rdy, b_so, b_busy, b_done;
  logic [3:0] b_q, b_rx;

  shift_exchange_ctrl #(.WIDTH(4), .DIV(1)) dut_b (
    .Clk(clk), .Rst(rst), .In(b_in), .Dir(b_dir), .InValid(b_valid),
    .InReady(b_rdy), .SerialIn(b_so), .SerialOut(b_so), .Q(b_q),
    .Busy(b_busy), .Done(b_done), .RxWord(b_rx)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expout[j] / sinseq[j] are the j-th serial bit out / in.
  task automatic run_a(input string tag, input logic [3:0] word, input logic d,
                       input logic [3:0] sinseq, input logic lb, input logic noise,
                       input logic [3:0] expout, input logic [3:0] exprx);
    a_in = word; a_dir = d; a_valid = 1'b1; loop_a = lb; a_sin = sinseq[0];
    step();
    a_valid = 1'b0;
    chk({tag, "_q_load"}, a_q, word);
    for (int j = 0; j < 4; j++) begin
      a_sin = sinseq[j];
      for (int k = 0; k < 2; k++) begin
        if (noise) begin
          a_valid = 1'b1; a_in = ~word; a_dir = ~d;
        end
        chk({tag, "_sout"}, a_so, expout[j]);
        chk({tag, "_busy"}, a_busy, 1'b1);
        chk({tag, "_rdy_low"}, a_rdy, 1'b0);
        chk({tag, "_nodone"}, a_done, 1'b0);
        step();
      end
    end
    a_valid = 1'b0; a_in = word; a_dir = d;
    chk({tag, "_done"}, a_done, 1'b1);
    chk({tag, "_rx"}, a_rx, exprx);
    chk({tag, "_sout_done"}, a_so, 1'b0);
    chk({tag, "_rdy_done"}, a_rdy, 1'b0);
    step();
    chk({tag, "_done_clr"}, a_done, 1'b0);
    chk({tag, "_rdy_back"}, a_rdy, 1'b1);
    chk({tag, "_rx_hold"}, a_rx, exprx);
    chk({tag, "_busy_clr"}, a_busy, 1'b0);
  endtask

  int done_cnt;

  initial begin
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_rdy", a_rdy, 1'b1);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_sout", a_so, 1'b0);
    chk("rst_q", a_q, 4'b0000);
    chk("rst_rx", a_rx, 4'b0000);
    chk("rst_b_rdy", b_rdy, 1'b1);

    // right shift, zero in: out 1,1,0,1 ; rx 0000
    run_a("t1", 4'b1011, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1011, 4'b0000);
    // left shift, in 1,1,0,1: out 1,0,1,1 ; rx 1101
    run_a("t2", 4'b1011, 1'b1, 4'b1011, 1'b0, 1'b0, 4'b1101, 4'b1101);
    // loopback both directions
    run_a("t3r", 4'b0110, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0110, 4'b0110);
    run_a("t3l", 4'b0110, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0110, 4'b0110);
    // inputs toggled during SHIFT are ignored
    run_a("t4n", 4'b1100, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b1100, 4'b1100);

    // reset during bit 2 (cycle 5)
    a_in = 4'b1011; a_dir = 1'b0; a_valid = 1'b1; loop_a = 1'b1;
    step();
    a_valid = 1'b0;
    repeat (4) step();
    chk("t4_pre_busy", a_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("t4_rst_q", a_q, 4'b0000);
    chk("t4_rst_sout", a_so, 1'b0);
    chk("t4_rst_busy", a_busy, 1'b0);
    chk("t4_rst_rdy", a_rdy, 1'b1);
    chk("t4_rst_done", a_done, 1'b0);
    chk("t4_rst_rx", a_rx, 4'b0000);
    #2;
    rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (a_done) done_cnt++;
    end
    chk("t4_no_done", done_cnt, 0);
    chk("t4_idle_rdy", a_rdy, 1'b1);

    // back-to-back with InValid held high
    a_in = 4'b1001; a_dir = 1'b0; a_valid = 1'b1; loop_a = 1'b1;
    done_cnt = 0;
    step();
    for (int c = 1; c <= 20; c++) begin
      if (c == 1) a_in = 4'b0101;
      if (a_done) done_cnt++;
      if (c == 9)  begin chk("t5_done1", a_done, 1'b1); chk("t5_rx1", a_rx, 4'b1001); end
      if (c == 10) chk("t5_rdy1", a_rdy, 1'b1);
      if (c == 11) begin chk("t5_busy2", a_busy, 1'b1); chk("t5_q2", a_q, 4'b0101); a_valid = 1'b0; end
      if (c == 19) begin chk("t5_done2", a_done, 1'b1); chk("t5_rx2", a_rx, 4'b0101); end
      if (c == 20) chk("t5_rdy2", a_rdy, 1'b1);
      step();
    end
    chk("t5_done_cnt", done_cnt, 2);

    // DIV=1 loopback: bits 1,0,0,1 on cycles 1..4, Done in cycle 5
    b_in = 4'b1001; b_dir = 1'b0; b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("t6_sout", b_so, (c == 1 || c == 4) ? 1'b1 : 1'b0);
      chk("t6_busy", b_busy, 1'b1);
      chk("t6_nodone", b_done, 1'b0);
      step();
    end
    chk("t6_done", b_done, 1'b1);
    chk("t6_rx", b_rx, 4'b1001);
    step();
    chk("t6_rdy", b_rdy, 1'b1);
    chk("t6_done_clr", b_done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
